multicycle_controller: RTL and testbench

Multicycle control FSM for the RV32I core. It sequences a shared-memory multicycle datapath: PC, IR, OldPC, ALUOut and MDR registers, a single unified memory port, the register file and the ALU. The datapath executes one instruction over 3–5 states. Each memory access uses a req/ready handshake, so the memory may insert wait states. It replaces the single-cycle main decoding path and reuses the existing ALU-function decoding.

---
 rtl/rv_ctrl_pkg.sv | 65 ++++++
 rtl/alu_decoder.sv | 28 ++
 rtl/multicycle_controller.sv | 162 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control path: states, opcodes, mux selects, ALU codes.
// Pure declarations; no timing or backpressure of its own.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_EXECU, S_ALUWB, S_BRANCH, S_JALR_ADR, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        logic [2:0] sel;
        case (op)
            OP_STORE:          sel = IMM_S;
            OP_BRANCH:         sel = IMM_B;
            OP_LUI, OP_AUIPC:  sel = IMM_U;
            OP_JAL:            sel = IMM_J;
            default:           sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU function decode from the internal ALU op, funct3 and funct7 bit 5.
// Purely combinational, zero latency; no backpressure.
module alu_decoder import rv_ctrl_pkg::*; (
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] aluop,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        if (aluop == ALUOP_FUNCT) begin
            case (funct3)
                // instr[30] only means SUB for register-register ops; ADDI ignores it
                3'b000:  alu_control = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_control = ALU_SLL;
                3'b010:  alu_control = ALU_SLT;
                3'b011:  alu_control = ALU_SLTU;
                3'b100:  alu_control = ALU_XOR;
                3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_control = ALU_OR;
                default: alu_control = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM sequencing a shared-memory datapath.
// 3-5 states per instruction with zero-wait memory; each memory wait cycle adds one.
// Memory accesses hold mem_req/MemWrite/AdrSrc stable until mem_ready is sampled high.
module multicycle_controller import rv_ctrl_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWEn,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSel,
    output logic        BrUn,
    output logic [3:0]  ALUControl,
    output logic        illegal,
    output logic [3:0]  state_o
);

    state_t     state, state_n;
    logic       illegal_q;
    logic [1:0] aluop;
    logic       mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_wen_s;
    logic [6:0] opcode;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .opb5        (opcode[5]),
        .funct3      (instr[14:12]),
        .funct7b5    (instr[30]),
        .aluop       (aluop),
        .alu_control (ALUControl)
    );

    always_comb begin
        state_n     = state;
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_wen_s   = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        ResultSrc   = RES_ALUOUT;
        aluop       = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALU;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
                state_n    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_R:              state_n = S_EXECR;
                    OP_I:              state_n = S_EXECI;
                    OP_BRANCH:         state_n = S_BRANCH;
                    OP_JAL:            state_n = S_JAL;
                    OP_JALR:           state_n = S_JALR_ADR;
                    OP_LUI, OP_AUIPC:  state_n = S_EXECU;
                    default:           state_n = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_n = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                AdrSrc    = 1'b1;
                state_n   = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = RES_MDR;
                reg_wen_s = 1'b1;
                state_n   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                AdrSrc      = 1'b1;
                state_n     = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                aluop   = ALUOP_FUNCT;
                state_n = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                state_n = S_ALUWB;
            end
            S_EXECU: begin
                // LUI adds the U-immediate to zero, AUIPC to the fetched PC
                ALUSrcA = opcode[5] ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wen_s = 1'b1;
                state_n   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                pc_write_s = br_taken;
                state_n    = S_FETCH;
            end
            S_JALR_ADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_n = S_JAL;
            end
            S_JAL: begin
                // PC takes ALUOut while the ALU forms OldPC+4 for the link write
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_write_s = 1'b1;
                state_n    = S_ALUWB;
            end
            default: state_n = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n == S_TRAP) illegal_q <= 1'b1;
        end
    end

    assign mem_req  = mem_req_s   & ~rst;
    assign MemWrite = mem_write_s & ~rst;
    assign IRWrite  = ir_write_s  & ~rst;
    assign PCWrite  = pc_write_s  & ~rst;
    assign RegWEn   = reg_wen_s   & ~rst;
    assign ImmSel   = imm_sel(opcode);
    assign BrUn     = instr[13];
    assign illegal  = illegal_q;
    assign state_o  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller with a queue-based scoreboard.
module tb_multicycle_controller;
    import rv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWEn, BrUn, illegal;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0]  ImmSel;
    logic [3:0]  ALUControl, state_o;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWEn(RegWEn), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSel(ImmSel), .BrUn(BrUn), .ALUControl(ALUControl),
        .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // strobe vectors {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWEn}
    localparam logic [5:0] SB_NONE = 6'b000000;
    localparam logic [5:0] SB_FW   = 6'b100000;
    localparam logic [5:0] SB_FR   = 6'b100110;
    localparam logic [5:0] SB_RD   = 6'b101000;
    localparam logic [5:0] SB_WR   = 6'b111000;
    localparam logic [5:0] SB_PCW  = 6'b000010;
    localparam logic [5:0] SB_REGW = 6'b000001;

    typedef struct {
        logic [3:0] st;
        logic [5:0] stb;
        logic [1:0] a, b, r;
        logic [2:0] msk;
        logic       chk_imm;
        logic [2:0] imm;
        logic       brun;
        logic       chk_alu;
        logic [3:0] alu;
        logic       ill;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    tests = 0;
    int    fails = 0;
    logic       cur_chk_imm = 1'b1;
    logic [2:0] cur_imm = 3'b000;
    logic       cur_brun = 1'b0;

    task automatic set_instr(input logic [31:0] ins, input logic ci, input logic [2:0] im, input logic bu);
        instr       = ins;
        cur_chk_imm = ci;
        cur_imm     = im;
        cur_brun    = bu;
    endtask

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic cyc(input string nm, input logic rdy, input logic brt, input logic r,
                       input state_t st, input logic [5:0] stb, input logic ca, input logic [3:0] alu);
        exp_t e;
        mem_ready = rdy;
        br_taken  = brt;
        rst       = r;
        e.st = st; e.stb = stb; e.chk_imm = cur_chk_imm; e.imm = cur_imm; e.brun = cur_brun;
        e.chk_alu = ca; e.alu = alu; e.ill = (st == S_TRAP);
        e.a = 2'b00; e.b = 2'b00; e.r = 2'b00; e.msk = 3'b000;
        case (st)
            S_FETCH:    begin e.a = 2'b00; e.b = 2'b10; e.r = 2'b10; e.msk = 3'b111; end
            S_DECODE:   begin e.a = 2'b01; e.b = 2'b01; e.msk = 3'b110; end
            S_MEMADR:   begin e.a = 2'b10; e.b = 2'b01; e.msk = 3'b110; end
            S_MEMREAD:  begin e.r = 2'b00; e.msk = 3'b001; end
            S_MEMWB:    begin e.r = 2'b01; e.msk = 3'b001; end
            S_EXECR:    begin e.a = 2'b10; e.b = 2'b00; e.msk = 3'b110; end
            S_EXECI:    begin e.a = 2'b10; e.b = 2'b01; e.msk = 3'b110; end
            S_EXECU:    begin e.b = 2'b01; e.msk = 3'b010; end
            S_ALUWB:    begin e.r = 2'b00; e.msk = 3'b001; end
            S_BRANCH:   begin e.a = 2'b10; e.b = 2'b00; e.r = 2'b00; e.msk = 3'b111; end
            S_JALR_ADR: begin e.a = 2'b10; e.b = 2'b01; e.msk = 3'b110; end
            S_JAL:      begin e.a = 2'b01; e.b = 2'b10; e.r = 2'b00; e.msk = 3'b111; end
            default:    e.msk = 3'b000;
        endcase
        if (st == S_FETCH || st == S_DECODE || st == S_MEMADR || st == S_JALR_ADR || st == S_JAL) begin
            e.chk_alu = 1'b1;
            e.alu     = ALU_ADD;
        end
        q.push_back(e);
        nq.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    exp_t       me;
    string      mn;
    logic       ok;
    logic [5:0] act_stb, stb_m;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            me = q.pop_front();
            mn = nq.pop_front();
            act_stb = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWEn};
            stb_m   = me.stb[5] ? 6'b111111 : 6'b110111;
            ok = (state_o === me.st)
                 && ((act_stb & stb_m) === (me.stb & stb_m))
                 && (!me.msk[2] || ALUSrcA === me.a)
                 && (!me.msk[1] || ALUSrcB === me.b)
                 && (!me.msk[0] || ResultSrc === me.r)
                 && (!me.chk_imm || ImmSel === me.imm)
                 && (BrUn === me.brun)
                 && (!me.chk_alu || ALUControl === me.alu)
                 && (illegal === me.ill);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL %s: got st=%0d stb=%b A=%b B=%b R=%b imm=%b brun=%b alu=%h ill=%b; want st=%0d stb=%b A=%b B=%b R=%b imm=%b brun=%b alu=%h ill=%b",
                         mn, state_o, act_stb, ALUSrcA, ALUSrcB, ResultSrc, ImmSel, BrUn, ALUControl, illegal,
                         me.st, me.stb, me.a, me.b, me.r, me.imm, me.brun, me.alu, me.ill);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        set_instr(32'h00000000, 1'b1, 3'b000, 1'b0);
        cyc("reset0", 1, 0, 1, S_FETCH, SB_NONE, 0, 4'h0);
        cyc("reset1", 1, 0, 1, S_FETCH, SB_NONE, 0, 4'h0);

        // add x3,x1,x2
        set_instr(32'h002081B3, 1'b0, 3'b000, 1'b0);
        cyc("add_fetch",  1, 0, 0, S_FETCH,  SB_FR,   0, 4'h0);
        cyc("add_decode", 1, 0, 0, S_DECODE, SB_NONE, 0, 4'h0);
        cyc("add_exec",   1, 0, 0, S_EXECR,  SB_NONE, 1, ALU_ADD);
        cyc("add_wb",     1, 0, 0, S_ALUWB,  SB_REGW, 0, 4'h0);

        // sub x3,x1,x2
        set_instr(32'h402081B3, 1'b0, 3'b000, 1'b0);
        cyc("sub_fetch",  1, 0, 0, S_FETCH,  SB_FR,   0, 4'h0);
        cyc("sub_decode", 1, 0, 0, S_DECODE, SB_NONE, 0, 4'h0);
        cyc("sub_exec",   1, 0, 0, S_EXECR,  SB_NONE, 1, ALU_SUB);
        cyc("sub_wb",     1, 0, 0, S_ALUWB,  SB_REGW, 0, 4'h0);

        // sra x3,x1,x2
        set_instr(32'h4020D1B3, 1'b0, 3'b000, 1'b0);
        cyc("sra_fetch",  1, 0, 0, S_FETCH,  SB_FR,   0, 4'h0);
        cyc("sra_decode", 1, 0, 0, S_DECODE, SB_NONE, 0, 4'h0);
        cyc("sra_exec",   1, 0, 0, S_EXECR,  SB_NONE, 1, ALU_SRA);
        cyc("sra_wb",     1, 0, 0, S_ALUWB,  SB_REGW, 0, 4'h0);

        // addi x5,x1,-1 : instr[30]=1 must still decode as add
        set_instr(32'hFFF08293, 1'b1, 3'b000, 1'b0);
        cyc("addi_fetch",  1, 0, 0, S_FETCH,  SB_FR,   0, 4'h0);
        cyc("addi_decode", 1, 0, 0, S_DECODE, SB_NONE, 0, 4'h0);
        cyc("addi_exec",   1, 0, 0, S_EXECI,  SB_NONE, 1, ALU_ADD);
        cyc("addi_wb",     1, 0, 0, S_ALUWB,  SB_REGW, 0, 4'h0);

        // lw x5,8(x1) with three wait cycles on the read
        set_instr(32'h0080A283, 1'b1, 3'b000, 1'b1);
        cyc("lw_fetch",  1, 0, 0, S_FETCH,   SB_FR,   0, 4'h0);
        cyc("lw_decode", 1, 0, 0, S_DECODE,  SB_NONE, 0, 4'h0);
        cyc("lw_adr",    0, 0, 0, S_MEMADR,  SB_NONE, 0, 4'h0);
        cyc("lw_wait1",  0, 0, 0, S_MEMREAD, SB_RD,   0, 4'h0);
        cyc("lw_wait2",  0, 0, 0, S_MEMREAD, SB_RD,   0, 4'h0);
        cyc("lw_wait3",  0, 0, 0, S_MEMREAD, SB_RD,   0, 4'h0);
        cyc("lw_read",   1, 0, 0, S_MEMREAD, SB_RD,   0, 4'h0);
        cyc("lw_wb",     1, 0, 0, S_MEMWB,   SB_REGW, 0, 4'h0);

        // sw x2,4(x1) with one fetch wait
        set_instr(32'h0020A223, 1'b1, 3'b001, 1'b1);
        cyc("sw_fwait",  0, 0, 0, S_FETCH,    SB_FW,   0, 4'h0);
        cyc("sw_fetch",  1, 0, 0, S_FETCH,    SB_FR,   0, 4'h0);
        cyc("sw_decode", 1, 0, 0, S_DECODE,   SB_NONE, 0, 4'h0);
        cyc("sw_adr",    1, 0, 0, S_MEMADR,   SB_NONE, 0, 4'h0);
        cyc("sw_write",  1, 0, 0, S_MEMWRITE, SB_WR,   0, 4'h0);

        // beq not taken, then taken
        set_instr(32'h00208463, 1'b1, 3'b010, 1'b0);
        cyc("beq0_fetch",  1, 0, 0, S_FETCH,  SB_FR,   0, 4'h0);
        cyc("beq0_decode", 1, 0, 0, S_DECODE, SB_NONE, 0, 4'h0);
        cyc("beq0_branch", 1, 0, 0, S_BRANCH, SB_NONE, 0, 4'h0);
        cyc("beq1_fetch",  1, 0, 0, S_FETCH,  SB_FR,   0, 4'h0);
        cyc("beq1_decode", 1, 0, 0, S_DECODE, SB_NONE, 0, 4'h0);
        cyc("beq1_branch", 1, 1, 0, S_BRANCH, SB_PCW,  0, 4'h0);

        // bltu taken: unsigned compare
        set_instr(32'h0020E463, 1'b1, 3'b010, 1'b1);
        cyc("bltu_fetch",  1, 0, 0, S_FETCH,  SB_FR,   0, 4'h0);
        cyc("bltu_decode", 1, 0, 0, S_DECODE, SB_NONE, 0, 4'h0);
        cyc("bltu_branch", 1, 1, 0, S_BRANCH, SB_PCW,  0, 4'h0);

        // jal x1,16
        set_instr(32'h010000EF, 1'b1, 3'b100, 1'b0);
        cyc("jal_fetch",  1, 0, 0, S_FETCH,  SB_FR,   0, 4'h0);
        cyc("jal_decode", 1, 0, 0, S_DECODE, SB_NONE, 0, 4'h0);
        cyc("jal_jal",    1, 0, 0, S_JAL,    SB_PCW,  0, 4'h0);
        cyc("jal_wb",     1, 0, 0, S_ALUWB,  SB_REGW, 0, 4'h0);

        // jalr x1,0(x6)
        set_instr(32'h000300E7, 1'b1, 3'b000, 1'b0);
        cyc("jalr_fetch",  1, 0, 0, S_FETCH,    SB_FR,   0, 4'h0);
        cyc("jalr_decode", 1, 0, 0, S_DECODE,   SB_NONE, 0, 4'h0);
        cyc("jalr_adr",    1, 0, 0, S_JALR_ADR, SB_NONE, 0, 4'h0);
        cyc("jalr_jal",    1, 0, 0, S_JAL,      SB_PCW,  0, 4'h0);
        cyc("jalr_wb",     1, 0, 0, S_ALUWB,    SB_REGW, 0, 4'h0);

        // lui x5,0x12345
        set_instr(32'h123452B7, 1'b1, 3'b011, 1'b0);
        cyc("lui_fetch",  1, 0, 0, S_FETCH,  SB_FR,   0, 4'h0);
        cyc("lui_decode", 1, 0, 0, S_DECODE, SB_NONE, 0, 4'h0);
        cyc("lui_exec",   1, 0, 0, S_EXECU,  SB_NONE, 0, 4'h0);
        cyc("lui_wb",     1, 0, 0, S_ALUWB,  SB_REGW, 0, 4'h0);

        // reset in the middle of a stalled store
        set_instr(32'h0020A223, 1'b1, 3'b001, 1'b1);
        cyc("swr_fetch",   1, 0, 0, S_FETCH,    SB_FR,   0, 4'h0);
        cyc("swr_decode",  1, 0, 0, S_DECODE,   SB_NONE, 0, 4'h0);
        cyc("swr_adr",     1, 0, 0, S_MEMADR,   SB_NONE, 0, 4'h0);
        cyc("swr_wait",    0, 0, 0, S_MEMWRITE, SB_WR,   0, 4'h0);
        cyc("swr_rst",     0, 0, 1, S_MEMWRITE, SB_NONE, 0, 4'h0);
        cyc("swr_refetch", 0, 0, 0, S_FETCH,    SB_FW,   0, 4'h0);
        cyc("swr_fetch",   1, 0, 0, S_FETCH,    SB_FR,   0, 4'h0);
        cyc("swr_decode2", 1, 0, 0, S_DECODE,   SB_NONE, 0, 4'h0);
        cyc("swr_adr2",    1, 0, 0, S_MEMADR,   SB_NONE, 0, 4'h0);
        cyc("swr_write",   1, 0, 0, S_MEMWRITE, SB_WR,   0, 4'h0);

        // illegal opcode 0x7F, sticky until reset
        set_instr(32'h0000007F, 1'b1, 3'b000, 1'b0);
        cyc("ill_fetch",  1, 0, 0, S_FETCH,  SB_FR,   0, 4'h0);
        cyc("ill_decode", 1, 0, 0, S_DECODE, SB_NONE, 0, 4'h0);
        for (int i = 0; i < 10; i++) cyc("ill_trap", 1, 1, 0, S_TRAP, SB_NONE, 0, 4'h0);
        cyc("ill_rst",    1, 0, 1, S_TRAP,   SB_NONE, 0, 4'h0);
        cyc("ill_after",  1, 0, 0, S_FETCH,  SB_FR,   0, 4'h0);

        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
